// File: rtl/bcd_counter_segscan.sv
//------------------------------------------------------------------------------
// Module      : bcd_counter_segscan
// Description : Multi-digit up/down BCD counter with a multiplexed 7-segment
//               scan driver, carry/borrow pulse and optional zero blanking.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bcd_counter_segscan #(
  parameter int DIGITS         = 8,
  parameter int TICK_DIV       = 50_000_000,
  parameter int SCAN_DIV       = 50_000,
  parameter int BLANK_LZ       = 0,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  carry,
  output logic [DIGITS-1:0]     seg_com,
  output logic [7:0]            seg_data
);

  localparam int c_TW = $clog2(TICK_DIV);
  localparam int c_SW = $clog2(SCAN_DIV);
  localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [c_TW-1:0]   c_TICK_LAST = c_TW'(TICK_DIV - 1);
  localparam logic [c_TW-1:0]   c_TICK_ONE  = c_TW'(1);
  localparam logic [c_SW-1:0]   c_SCAN_LAST = c_SW'(SCAN_DIV - 1);
  localparam logic [c_SW-1:0]   c_SCAN_ONE  = c_SW'(1);
  localparam logic [c_IW-1:0]   c_IDX_LAST  = c_IW'(DIGITS - 1);
  localparam logic [c_IW-1:0]   c_IDX_ONE   = c_IW'(1);
  localparam logic [DIGITS-1:0] c_COM_OFF   = (COM_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        c_SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [c_TW-1:0]     r_tick_cnt;
  logic [c_SW-1:0]     r_scan_cnt;
  logic [c_IW-1:0]     r_idx;
  logic                r_outputs_on;
  logic                w_tick;
  logic                w_stick;
  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic                w_inc_cy;
  logic                w_dec_bw;
  logic [c_IW-1:0]     w_next_idx;
  logic [DIGITS-1:0]   w_com_hot;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_sel_digit;
  logic                w_sel_blank;

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 8'b11111100;
      4'd1:    seg_pattern = 8'b01100000;
      4'd2:    seg_pattern = 8'b11011010;
      4'd3:    seg_pattern = 8'b11110010;
      4'd4:    seg_pattern = 8'b01100110;
      4'd5:    seg_pattern = 8'b10110110;
      4'd6:    seg_pattern = 8'b10111110;
      4'd7:    seg_pattern = 8'b11100000;
      4'd8:    seg_pattern = 8'b11111110;
      4'd9:    seg_pattern = 8'b11110110;
      default: seg_pattern = 8'b00000000;
    endcase
  endfunction

  assign w_tick  = (r_tick_cnt == c_TICK_LAST);
  assign w_stick = (r_scan_cnt == c_SCAN_LAST);

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
    end
  end

  // Ripple increment/decrement across digits; the final carry/borrow marks a full wrap.
  always_comb begin
    w_inc    = count_bcd;
    w_dec    = count_bcd;
    w_inc_cy = 1'b1;
    w_dec_bw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_inc_cy) begin
        if (count_bcd[4*i +: 4] >= 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          w_inc_cy        = 1'b0;
        end
      end
      if (w_dec_bw) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          w_dec_bw        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      count_bcd <= '0;
      carry     <= 1'b0;
    end else if (clr) begin
      count_bcd <= '0;
      carry     <= 1'b0;
    end else if (w_tick && en) begin
      if (up_dn) begin
        count_bcd <= w_inc;
        carry     <= w_inc_cy;
      end else begin
        count_bcd <= w_dec;
        carry     <= w_dec_bw;
      end
    end else begin
      carry <= 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
    end else if (w_stick) begin
      r_scan_cnt <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + c_SCAN_ONE;
    end
  end

  // A digit is blanked when it and every more-significant digit are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_d0
      assign w_blank[gi] = 1'b0;
    end else begin : g_dn
      assign w_blank[gi] = (BLANK_LZ != 0) && ~|count_bcd[4*DIGITS-1:4*gi];
    end
  end

  always_comb begin
    if (!r_outputs_on || (r_idx == c_IDX_LAST)) begin
      w_next_idx = '0;
    end else begin
      w_next_idx = r_idx + c_IDX_ONE;
    end
  end

  always_comb begin
    w_com_hot   = '0;
    w_sel_digit = 4'd0;
    w_sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_next_idx == c_IW'(i)) begin
        w_com_hot[i] = 1'b1;
        w_sel_digit  = count_bcd[4*i +: 4];
        w_sel_blank  = w_blank[i];
      end
    end
  end

  // The first stick only switches the display on at digit 0.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_idx        <= '0;
      r_outputs_on <= 1'b0;
      seg_com      <= c_COM_OFF;
      seg_data     <= c_SEG_OFF;
    end else if (w_stick) begin
      r_idx        <= w_next_idx;
      r_outputs_on <= 1'b1;
      seg_com      <= w_com_hot ^ c_COM_OFF;
      seg_data     <= (w_sel_blank ? 8'h00 : seg_pattern(w_sel_digit)) ^ c_SEG_OFF;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_segscan.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_counter_segscan
// Description : Scoreboard bench for bcd_counter_segscan (4 digits, fast dividers).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_counter_segscan;

  logic        mclk = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic        up_dn = 1'b1;
  logic        clr  = 1'b0;
  logic [15:0] count_bcd, count_bcd_b;
  logic        carry, carry_b;
  logic [3:0]  seg_com, seg_com_b;
  logic [7:0]  seg_data, seg_data_b;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  bit disp_chk = 1'b0;

  logic [16:0] q_cnt[$];    // {count_bcd, carry}
  logic [11:0] q_disp[$];   // {seg_com, seg_data} of the plain DUT
  logic [11:0] q_blank[$];  // {seg_com, seg_data} of the blanking DUT

  always #5 mclk = ~mclk;

  bcd_counter_segscan #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2),
    .BLANK_LZ(0), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .mclk(mclk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .count_bcd(count_bcd), .carry(carry), .seg_com(seg_com), .seg_data(seg_data)
  );

  bcd_counter_segscan #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2),
    .BLANK_LZ(1), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut_blank (
    .mclk(mclk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .count_bcd(count_bcd_b), .carry(carry_b), .seg_com(seg_com_b), .seg_data(seg_data_b)
  );

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Edges since reset release; count steps land on multiples of 4.
  initial begin
    forever begin
      @(posedge mclk or negedge rst);
      if (!rst) edge_cnt = 0;
      else      edge_cnt++;
    end
  end

  // Count monitor: every change of count_bcd consumes one expected entry.
  initial begin
    logic [15:0] prev_cnt;
    logic        prev_carry;
    logic [16:0] e;
    prev_cnt   = '0;
    prev_carry = 1'b0;
    forever begin
      @(negedge mclk);
      if (!rst) begin
        prev_cnt   = count_bcd;
        prev_carry = 1'b0;
      end else begin
        if (prev_carry) begin
          checks++;
          if (carry !== 1'b0) begin
            errors++;
            $display("FAIL carry_width: actual carry=%b required carry=0", carry);
          end
        end
        if (count_bcd !== prev_cnt) begin
          checks++;
          if (q_cnt.size() == 0) begin
            errors++;
            $display("FAIL count_unexpected: actual count=%h required count=%h (no step expected)", count_bcd, prev_cnt);
          end else begin
            e = q_cnt.pop_front();
            if ({count_bcd, carry} !== e) begin
              errors++;
              $display("FAIL count_step: actual count=%h carry=%b required count=%h carry=%b",
                       count_bcd, carry, e[16:1], e[0]);
            end
          end
        end
        prev_cnt   = count_bcd;
        prev_carry = carry;
      end
    end
  end

  // Display monitor: each change of {seg_com, seg_data} consumes one entry per DUT.
  initial begin
    logic [11:0] pa, pb, e;
    bit          valid;
    pa = '0; pb = '0; valid = 1'b0;
    forever begin
      @(negedge mclk);
      if (disp_chk && valid) begin
        if ({seg_com, seg_data} !== pa) begin
          checks++;
          if (q_disp.size() == 0) begin
            errors++;
            $display("FAIL disp_main_unexpected: actual com=%b data=%b required no change", seg_com, seg_data);
          end else begin
            e = q_disp.pop_front();
            if ({seg_com, seg_data} !== e) begin
              errors++;
              $display("FAIL disp_main: actual com=%b data=%b required com=%b data=%b",
                       seg_com, seg_data, e[11:8], e[7:0]);
            end
          end
        end
        if ({seg_com_b, seg_data_b} !== pb) begin
          checks++;
          if (q_blank.size() == 0) begin
            errors++;
            $display("FAIL disp_blank_unexpected: actual com=%b data=%b required no change", seg_com_b, seg_data_b);
          end else begin
            e = q_blank.pop_front();
            if ({seg_com_b, seg_data_b} !== e) begin
              errors++;
              $display("FAIL disp_blank: actual com=%b data=%b required com=%b data=%b",
                       seg_com_b, seg_data_b, e[11:8], e[7:0]);
            end
          end
        end
      end
      pa    = {seg_com, seg_data};
      pb    = {seg_com_b, seg_data_b};
      valid = disp_chk;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    do begin
      @(posedge mclk);
      #1;
    end while (edge_cnt % 4 != p);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_cnt.size() != 0 || q_disp.size() != 0 || q_blank.size() != 0) && n < 3000) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: actual pending=%0d/%0d/%0d required 0/0/0",
               name, q_cnt.size(), q_disp.size(), q_blank.size());
      q_cnt.delete();
      q_disp.delete();
      q_blank.delete();
    end
  endtask

  // Land on the first negedge after digit 0 becomes selected.
  task automatic sync_digit0();
    int n = 0;
    @(negedge mclk);
    while (seg_com == 4'b1110 && n < 40) begin @(negedge mclk); n++; end
    while (seg_com != 4'b1110 && n < 40) begin @(negedge mclk); n++; end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL sync_digit0: actual com=%b required com=1110", seg_com);
    end
  endtask

  task automatic push_zero_scan();
    q_disp.push_back({4'b1110, 8'b11111100});
    q_disp.push_back({4'b1101, 8'b11111100});
    q_disp.push_back({4'b1011, 8'b11111100});
    q_disp.push_back({4'b0111, 8'b11111100});
    q_blank.push_back({4'b1110, 8'b11111100});
    q_blank.push_back({4'b1101, 8'b00000000});
    q_blank.push_back({4'b1011, 8'b00000000});
    q_blank.push_back({4'b0111, 8'b00000000});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},    32'(count_bcd),   32'h0);
    chk({tag, "_carry"},    32'(carry),       32'h0);
    chk({tag, "_com"},      32'(seg_com),     32'hF);
    chk({tag, "_data"},     32'(seg_data),    32'h00);
    chk({tag, "_count_b"},  32'(count_bcd_b), 32'h0);
    chk({tag, "_carry_b"},  32'(carry_b),     32'h0);
    chk({tag, "_com_b"},    32'(seg_com_b),   32'hF);
    chk({tag, "_data_b"},   32'(seg_data_b),  32'h00);
  endtask

  initial begin
    #52;
    chk_reset_state("reset");

    // First stick after release shows digit 0; blanking DUT hides zeros above it.
    push_zero_scan();
    disp_chk = 1'b1;
    #48 rst = 1'b1;
    wait_drain("first_scan");
    disp_chk = 1'b0;

    // Count up 0001 .. 0123.
    for (int n = 1; n <= 123; n++) q_cnt.push_back({to_bcd(n), 1'b0});
    wait_phase(1);
    en = 1'b1;
    wait_drain("count_up");
    en = 1'b0;

    // Display of 0123, starting from the digit after digit 0.
    sync_digit0();
    q_disp.push_back({4'b1101, 8'b11011010});
    q_disp.push_back({4'b1011, 8'b01100000});
    q_disp.push_back({4'b0111, 8'b11111100});
    q_disp.push_back({4'b1110, 8'b11110010});
    q_blank.push_back({4'b1101, 8'b11011010});
    q_blank.push_back({4'b1011, 8'b01100000});
    q_blank.push_back({4'b0111, 8'b00000000});
    q_blank.push_back({4'b1110, 8'b11110010});
    disp_chk = 1'b1;
    wait_drain("scan_0123");
    disp_chk = 1'b0;

    // Clear wins over an enabled tick.
    q_cnt.push_back({16'h0000, 1'b0});
    wait_phase(3);
    en  = 1'b1;
    clr = 1'b1;
    wait_phase(0);
    en  = 1'b0;
    clr = 1'b0;
    wait_drain("clear");
    repeat (40) @(posedge mclk);
    #1 chk("hold_en0_count", 32'(count_bcd), 32'h0);

    // Down wrap 0000 -> 9999, then up wrap 9999 -> 0000, both with carry.
    wait_phase(1);
    q_cnt.push_back({16'h9999, 1'b1});
    up_dn = 1'b0;
    en    = 1'b1;
    wait_phase(1);
    q_cnt.push_back({16'h0000, 1'b1});
    up_dn = 1'b1;
    wait_phase(1);
    q_cnt.push_back({16'h0001, 1'b0});
    wait_phase(1);
    en = 1'b0;
    wait_drain("wrap");

    // Leading-zero blanking at 0007.
    for (int n = 2; n <= 7; n++) q_cnt.push_back({to_bcd(n), 1'b0});
    wait_phase(1);
    en = 1'b1;
    wait_drain("count_to_7");
    en = 1'b0;
    sync_digit0();
    q_disp.push_back({4'b1101, 8'b11111100});
    q_disp.push_back({4'b1011, 8'b11111100});
    q_disp.push_back({4'b0111, 8'b11111100});
    q_disp.push_back({4'b1110, 8'b11100000});
    q_blank.push_back({4'b1101, 8'b00000000});
    q_blank.push_back({4'b1011, 8'b00000000});
    q_blank.push_back({4'b0111, 8'b00000000});
    q_blank.push_back({4'b1110, 8'b11100000});
    disp_chk = 1'b1;
    wait_drain("scan_0007");
    disp_chk = 1'b0;

    // Asynchronous reset in the middle of a count and scan period.
    q_cnt.push_back({16'h0008, 1'b0});
    wait_phase(1);
    en = 1'b1;
    wait_phase(1);
    wait_phase(2);
    #3 rst = 1'b0;
    en = 1'b0;
    #1 chk_reset_state("async_reset");
    push_zero_scan();
    disp_chk = 1'b1;
    #20 rst = 1'b1;
    wait_drain("post_reset_scan");
    disp_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
